// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared button indices, channel state type and timing defaults
// Revision    : 1.0
// ============================================================================
package clock_pkg;

    localparam int BTN_RESET      = 0;
    localparam int BTN_MODE       = 1;
    localparam int BTN_EDIT_SHIFT = 2;
    localparam int BTN_INC        = 3;
    localparam int BTN_START_STOP = 4;
    localparam int NUM_BUTTONS    = 5;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_HOLD_CYCLES     = 15_000_000;
    localparam int DEFAULT_REPEAT_CYCLES   = 5_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2,
        LOCKED  = 2'd3
    } chan_state_t;

    // Width of a counter that must hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_gen_if
// Description : Button-event strobes from the conditioner to the mode controller
// Revision    : 1.0
// ============================================================================
interface button_event_gen_if
    import clock_pkg::*;
#(
    parameter int NUM_BTNS = NUM_BUTTONS
);
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] press_pulse;
    logic [NUM_BTNS-1:0] short_pulse;
    logic [NUM_BTNS-1:0] long_pulse;
    logic [NUM_BTNS-1:0] repeat_pulse;
    logic [NUM_BTNS-1:0] release_pulse;
    logic                busy;
    logic [2:0]          active_id;

    modport master (
        output btn_level, press_pulse, short_pulse, long_pulse,
               repeat_pulse, release_pulse, busy, active_id
    );

    modport slave (
        input  btn_level, press_pulse, short_pulse, long_pulse,
               repeat_pulse, release_pulse, busy, active_id
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer and stable-count debouncer per button
// Revision    : 1.0
// ============================================================================
module btn_debounce
    import clock_pkg::*;
#(
    parameter int NUM_BTNS        = NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic [NUM_BTNS-1:0] btn_raw,
    output logic      [NUM_BTNS-1:0] btn_sync,
    output logic      [NUM_BTNS-1:0] btn_level
);
    localparam int                 c_CNT_W    = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_bit
            logic               r_meta;
            logic               r_sync;
            logic               r_level;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_meta  <= 1'b0;
                    r_sync  <= 1'b0;
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_meta <= btn_raw[gi];
                    r_sync <= r_meta;
                    // Any sample that agrees with the accepted level restarts the count.
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= c_CNT_LAST) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign btn_sync[gi]  = r_sync;
            assign btn_level[gi] = r_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : button_event_gen
// Description : Debounced button channels with single-owner press/short/long/repeat strobes
// Revision    : 1.0
// ============================================================================
module button_event_gen
    import clock_pkg::*;
#(
    parameter int NUM_BTNS        = NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic [NUM_BTNS-1:0] btn_raw,
    button_event_gen_if.master       evt
);
    localparam int                  c_HOLD_W    = cnt_width(HOLD_CYCLES - 1);
    localparam int                  c_REP_W     = cnt_width(REPEAT_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = (REPEAT_CYCLES > 0) ? c_REP_W'(REPEAT_CYCLES - 1) : '0;

    logic [NUM_BTNS-1:0] w_sync, w_level, r_level_d, w_rise, w_fall;
    logic [NUM_BTNS-1:0] r_armed, w_armed_nxt, w_grant;
    logic [NUM_BTNS-1:0] w_press, w_short, w_long, w_repeat, w_release;
    chan_state_t         r_state     [NUM_BTNS];
    chan_state_t         w_state_nxt [NUM_BTNS];
    logic [c_HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [c_REP_W-1:0]  r_rep, w_rep_nxt;
    logic [1:0]          r_warm;
    logic                w_owned, w_grant_any;
    logic [2:0]          w_owner_id, w_grant_id;

    btn_debounce #(
        .NUM_BTNS        (NUM_BTNS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_sync  (w_sync),
        .btn_level (w_level)
    );

    assign w_rise = w_level & ~r_level_d;
    assign w_fall = ~w_level & r_level_d;
    // A channel may only win ownership once it has been seen released since reset.
    assign w_armed_nxt = r_armed | w_fall | ({NUM_BTNS{r_warm[1]}} & ~w_sync & ~w_level);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTNS; i++) r_state[i] <= IDLE;
            r_level_d <= '0;
            r_armed   <= '0;
            r_warm    <= '0;
            r_hold    <= '0;
            r_rep     <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) r_state[i] <= w_state_nxt[i];
            r_level_d <= w_level;
            r_armed   <= w_armed_nxt;
            r_warm    <= {r_warm[0], 1'b1};
            r_hold    <= w_hold_nxt;
            r_rep     <= w_rep_nxt;
        end
    end

    always_comb begin
        w_owned     = 1'b0;
        w_owner_id  = '0;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_press     = '0;
        w_short     = '0;
        w_long      = '0;
        w_repeat    = '0;
        w_release   = '0;
        w_hold_nxt  = '0;
        w_rep_nxt   = '0;
        for (int i = 0; i < NUM_BTNS; i++) w_state_nxt[i] = r_state[i];

        for (int i = 0; i < NUM_BTNS; i++) begin
            if (r_state[i] == PRESSED || r_state[i] == HELD) begin
                w_owned    = 1'b1;
                w_owner_id = 3'(i);
            end
        end

        // Ownership freed this cycle is not offered until the next one.
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (!w_owned && !w_grant_any && w_rise[i] && r_armed[i]) begin
                w_grant[i]  = 1'b1;
                w_grant_any = 1'b1;
                w_grant_id  = 3'(i);
            end
        end

        for (int i = 0; i < NUM_BTNS; i++) begin
            case (r_state[i])
                IDLE: begin
                    if (w_rise[i]) begin
                        if (w_grant[i]) begin
                            w_state_nxt[i] = PRESSED;
                            w_press[i]     = 1'b1;
                            w_hold_nxt     = c_HOLD_W'(1);
                        end else begin
                            w_state_nxt[i] = LOCKED;
                        end
                    end
                end
                PRESSED: begin
                    if (w_fall[i]) begin
                        w_short[i]     = 1'b1;
                        w_release[i]   = 1'b1;
                        w_state_nxt[i] = IDLE;
                    end else if (r_hold >= c_HOLD_LAST) begin
                        w_long[i]      = 1'b1;
                        w_state_nxt[i] = HELD;
                    end else begin
                        w_hold_nxt = (r_hold == '1) ? r_hold : r_hold + 1'b1;
                    end
                end
                HELD: begin
                    if (w_fall[i]) begin
                        w_release[i]   = 1'b1;
                        w_state_nxt[i] = IDLE;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (r_rep >= c_REP_LAST) begin
                            w_repeat[i] = 1'b1;
                        end else begin
                            w_rep_nxt = r_rep + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_fall[i]) w_state_nxt[i] = IDLE;
                end
                default: w_state_nxt[i] = IDLE;
            endcase
        end
    end

    assign evt.btn_level     = w_level;
    assign evt.press_pulse   = w_press;
    assign evt.short_pulse   = w_short;
    assign evt.long_pulse    = w_long;
    assign evt.repeat_pulse  = w_repeat;
    assign evt.release_pulse = w_release;
    assign evt.busy          = w_owned | w_grant_any;
    assign evt.active_id     = w_grant_any ? w_grant_id : w_owner_id;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_gen
// Description : Directed bench; expected strobes are queued ahead and matched as they appear
// Revision    : 1.0
// ============================================================================
module tb_button_event_gen;
    import clock_pkg::*;

    localparam int NB   = 5;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int LAT  = DEB + 2;

    localparam int K_PRESS   = 0;
    localparam int K_SHORT   = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;
    localparam int K_RELEASE = 4;

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } ev_t;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic [NB-1:0] btn_raw = '1;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    int  t, t0;
    ev_t exp_q[$];
    ev_t mon_e;
    logic [NB-1:0] pv [5];
    logic [4*NB-1:0] onehot_v;

    button_event_gen_if #(.NUM_BTNS(NB)) evt_if ();

    button_event_gen #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .evt     (evt_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input int k, input int idx);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic go_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every strobe seen must be the next queued expectation.
    always @(negedge clk) begin
        pv[K_PRESS]   = evt_if.press_pulse;
        pv[K_SHORT]   = evt_if.short_pulse;
        pv[K_LONG]    = evt_if.long_pulse;
        pv[K_REPEAT]  = evt_if.repeat_pulse;
        pv[K_RELEASE] = evt_if.release_pulse;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $error("FAIL missed_event observed=none expected=cyc%0d/kind%0d/idx%0d",
                   exp_q[0].cyc, exp_q[0].kind, exp_q[0].idx);
            void'(exp_q.pop_front());
        end
        onehot_v = {pv[K_PRESS], pv[K_SHORT], pv[K_LONG], pv[K_REPEAT]};
        if (|onehot_v) begin
            total++;
            assert ($countones(onehot_v) <= 1) else begin
                bad++;
                $error("FAIL strobe_onehot observed=%0h expected=at_most_one_bit", onehot_v);
            end
        end
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NB; i++) begin
                if (pv[k][i]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $error("FAIL unexpected_event observed=cyc%0d/kind%0d/idx%0d expected=none", cyc, k, i);
                    end else begin
                        mon_e = exp_q.pop_front();
                        assert (cyc === mon_e.cyc && k === mon_e.kind && i === mon_e.idx) else begin
                            bad++;
                            $error("FAIL event observed=cyc%0d/kind%0d/idx%0d expected=cyc%0d/kind%0d/idx%0d",
                                   cyc, k, i, mon_e.cyc, mon_e.kind, mon_e.idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with every button pressed
        reset   = 1'b0;
        btn_raw = '1;
        repeat (5) @(negedge clk);
        check("reset_level", 64'(evt_if.btn_level), 64'd0);
        check("reset_pulses", 64'({evt_if.press_pulse, evt_if.short_pulse, evt_if.long_pulse,
                                   evt_if.repeat_pulse, evt_if.release_pulse}), 64'd0);
        check("reset_busy_id", 64'({evt_if.busy, evt_if.active_id}), 64'd0);

        // Buttons still held after reset must not press
        reset = 1'b1;
        t = cyc;
        go_to(t + 20);
        check("held_after_reset_level", 64'(evt_if.btn_level), 64'h1f);
        check("held_after_reset_busy", 64'(evt_if.busy), 64'd0);
        btn_raw = '0;
        t = cyc;
        go_to(t + 12);
        check("released_level", 64'(evt_if.btn_level), 64'd0);

        // Re-press start_stop after release: now accepted
        t = cyc;
        btn_raw[BTN_START_STOP] = 1'b1;
        push(t + LAT, K_PRESS, BTN_START_STOP);
        push(t + LAT + 10, K_SHORT, BTN_START_STOP);
        push(t + LAT + 10, K_RELEASE, BTN_START_STOP);
        go_to(t + LAT);
        check("repress_owner", 64'({evt_if.busy, evt_if.active_id}), 64'h c);
        go_to(t + 10);
        btn_raw[BTN_START_STOP] = 1'b0;
        go_to(t + 30);
        check("repress_idle", 64'(evt_if.busy), 64'd0);

        // Three-cycle glitch on mode
        t = cyc;
        btn_raw[BTN_MODE] = 1'b1;
        go_to(t + 3);
        btn_raw[BTN_MODE] = 1'b0;
        go_to(t + 15);
        check("glitch_level", 64'(evt_if.btn_level[BTN_MODE]), 64'd0);

        // Clean mode press: level and press exactly LAT clocks after raw edge
        t = cyc;
        btn_raw[BTN_MODE] = 1'b1;
        push(t + LAT, K_PRESS, BTN_MODE);
        push(t + LAT + 10, K_SHORT, BTN_MODE);
        push(t + LAT + 10, K_RELEASE, BTN_MODE);
        go_to(t + LAT - 1);
        check("mode_level_early", 64'(evt_if.btn_level[BTN_MODE]), 64'd0);
        go_to(t + LAT);
        check("mode_level_edge", 64'(evt_if.btn_level[BTN_MODE]), 64'd1);
        check("mode_press_edge", 64'(evt_if.press_pulse), 64'h02);
        go_to(t + 10);
        btn_raw[BTN_MODE] = 1'b0;
        go_to(t + 30);

        // Short inc press
        t = cyc;
        btn_raw[BTN_INC] = 1'b1;
        push(t + LAT, K_PRESS, BTN_INC);
        push(t + LAT + 10, K_SHORT, BTN_INC);
        push(t + LAT + 10, K_RELEASE, BTN_INC);
        go_to(t + 10);
        btn_raw[BTN_INC] = 1'b0;
        go_to(t + LAT + 10);
        check("short_release_busy", 64'(evt_if.busy), 64'd1);
        check("short_pulse_bits", 64'({evt_if.short_pulse, evt_if.release_pulse}), 64'h108);
        go_to(t + LAT + 11);
        check("short_busy_drop", 64'(evt_if.busy), 64'd0);
        go_to(t + 30);

        // Long inc press with auto-repeat
        t = cyc;
        t0 = t + LAT;
        btn_raw[BTN_INC] = 1'b1;
        push(t0, K_PRESS, BTN_INC);
        push(t0 + HOLD - 1, K_LONG, BTN_INC);
        for (int r = 0; r < 4; r++) push(t0 + HOLD - 1 + REP * (r + 1), K_REPEAT, BTN_INC);
        push(t0 + 40, K_RELEASE, BTN_INC);
        go_to(t + 40);
        btn_raw[BTN_INC] = 1'b0;
        go_to(t + 60);

        // Simultaneous mode+inc: mode owns, inc locked out
        t = cyc;
        t0 = t + LAT;
        btn_raw[BTN_MODE] = 1'b1;
        btn_raw[BTN_INC]  = 1'b1;
        push(t0, K_PRESS, BTN_MODE);
        push(t0 + HOLD - 1, K_LONG, BTN_MODE);
        for (int r = 0; r < 4; r++) push(t0 + HOLD - 1 + REP * (r + 1), K_REPEAT, BTN_MODE);
        push(t0 + 40, K_RELEASE, BTN_MODE);
        go_to(t0);
        check("prio_owner", 64'({evt_if.busy, evt_if.active_id}), 64'h9);
        check("prio_press", 64'(evt_if.press_pulse), 64'h02);
        go_to(t + 10);
        btn_raw[BTN_INC] = 1'b0;
        go_to(t + 20);
        btn_raw[BTN_INC] = 1'b1;
        go_to(t + 40);
        btn_raw[BTN_MODE] = 1'b0;
        go_to(t0 + 41);
        check("prio_free_busy", 64'(evt_if.busy), 64'd0);
        check("prio_inc_level", 64'(evt_if.btn_level[BTN_INC]), 64'd1);
        go_to(t + 70);
        btn_raw[BTN_INC] = 1'b0;
        go_to(t + 85);
        check("prio_all_low", 64'(evt_if.btn_level), 64'd0);

        // Inc re-press after lockout is accepted again
        t = cyc;
        btn_raw[BTN_INC] = 1'b1;
        push(t + LAT, K_PRESS, BTN_INC);
        push(t + LAT + 10, K_SHORT, BTN_INC);
        push(t + LAT + 10, K_RELEASE, BTN_INC);
        go_to(t + 10);
        btn_raw[BTN_INC] = 1'b0;
        go_to(t + 30);

        // Reset at hold count 10 aborts the press; held button stays silent
        t = cyc;
        t0 = t + LAT;
        btn_raw[BTN_EDIT_SHIFT] = 1'b1;
        push(t0, K_PRESS, BTN_EDIT_SHIFT);
        go_to(t0 + 10);
        reset = 1'b0;
        #1;
        check("midreset_outputs", 64'({evt_if.btn_level, evt_if.press_pulse, evt_if.short_pulse,
                                       evt_if.long_pulse, evt_if.repeat_pulse, evt_if.release_pulse,
                                       evt_if.busy, evt_if.active_id}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        t = cyc;
        go_to(t + 50);
        check("midreset_level", 64'(evt_if.btn_level[BTN_EDIT_SHIFT]), 64'd1);
        check("midreset_busy", 64'(evt_if.busy), 64'd0);
        btn_raw[BTN_EDIT_SHIFT] = 1'b0;
        go_to(t + 65);
        check("final_level", 64'(evt_if.btn_level), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Conditions the raw push-button inputs (reset, mode, start_stop, edit_shift, inc) into clean, single-cycle event strobes for the clock/timer mode controller.
- It is the producer side of the button-event interface. The controller consumes strobes instead of running its own 15_000_000-cycle press counters.
- Sits between the board pins and the mode controller. One instance per board.

Parameters:
- NUM_BTNS, 5, number of buttons. Index 0=reset, 1=mode, 2=edit_shift, 3=inc, 4=start_stop; lower index has higher priority.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
- HOLD_CYCLES, 15_000_000, debounced-high cycles before a press counts as a long press.
- REPEAT_CYCLES, 5_000_000, period of auto-repeat strobes after a long press. 0 disables repeat.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- btn_raw  in  NUM_BTNS  raw asynchronous button levels, 1 = pressed
- btn_level  out  NUM_BTNS  debounced levels
- press_pulse  out  NUM_BTNS  1-cycle strobe on an accepted press
- short_pulse  out  NUM_BTNS  1-cycle strobe on release before long threshold
- long_pulse  out  NUM_BTNS  1-cycle strobe when hold reaches HOLD_CYCLES
- repeat_pulse  out  NUM_BTNS  1-cycle strobe every REPEAT_CYCLES after long_pulse while held
- release_pulse  out  NUM_BTNS  1-cycle strobe on debounced release of the owning button
- busy  out  1  a button currently owns the interface
- active_id  out  3  index of the owning button; 0 when not busy

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs 0.
  - Synchronizers, debounce counters and hold counters cleared.
  - All channels in IDLE.
  - Reset asserted mid-press aborts the press with no strobes. After reset deasserts, a button still held must first be seen released before it can produce a press.
- Synchronizer: 2 flops per bit.
- Debounce, per channel:
  - The counter increments while the synchronized bit differs from btn_level, and clears when they are equal.
  - When the count reaches DEBOUNCE_CYCLES-1, btn_level toggles on the next edge.
  - Latency from a clean raw edge to the btn_level change is DEBOUNCE_CYCLES+2 clocks.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Channel FSM states: IDLE, PRESSED, HELD, LOCKED.
  - IDLE -> PRESSED on a btn_level rise when not busy. press_pulse is asserted in the same cycle btn_level goes high. busy=1 and active_id=index from that cycle.
  - IDLE -> LOCKED on a btn_level rise while another channel owns the interface. No strobes are issued.
  - PRESSED: the hold counter counts cycles with btn_level high. When it reaches HOLD_CYCLES-1, long_pulse is asserted and the channel goes to HELD with the repeat counter cleared.
  - PRESSED, on a btn_level fall: short_pulse and release_pulse in the same cycle, then IDLE. busy drops on the next cycle.
  - HELD: when REPEAT_CYCLES>0, repeat_pulse fires each time the repeat counter reaches REPEAT_CYCLES-1, and the counter wraps to 0.
  - HELD, on a btn_level fall: release_pulse only, then IDLE.
  - LOCKED -> IDLE on a btn_level fall. No strobes.
- Simultaneous accepted rises on several channels: the lowest index takes ownership; the others go to LOCKED.
- At most one bit in total is set across press/short/long/repeat_pulse in any cycle.
- Counter widths are $clog2(max+1); counters saturate and never wrap.
- Ownership release and a new rise in the same cycle: the new rise goes to LOCKED. The freed interface is only visible on the following cycle.

Decomposition:
- Shared package (clock_pkg) holds:
  - button index constants BTN_RESET=0, BTN_MODE=1, BTN_EDIT_SHIFT=2, BTN_INC=3, BTN_START_STOP=4;
  - channel state typedef {IDLE, PRESSED, HELD, LOCKED};
  - default timing constants.
- One sub-module, btn_debounce: per-bit synchronizer plus debounce counter, outputs btn_level.
- The channel FSMs and the ownership arbiter live in button_event_gen.

Test Plan (simulation parameters DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5):
- Reset: hold reset=0 with btn_raw=5'b11111 -> all outputs 0. Release reset with buttons still held -> no press_pulse until each button is released and pressed again.
- Glitch: raw mode high for 3 cycles -> btn_level[1] stays 0, no strobes. Raw mode high for 10 cycles -> btn_level[1] and press_pulse[1] rise exactly 6 clocks after the raw edge.
- Short press: inc held for 10 cycles -> press_pulse[3] once. On release: short_pulse[3] and release_pulse[3] in the same cycle. No long_pulse.
- Long press with repeat: inc held for 40 debounced cycles -> press_pulse at t0, long_pulse at t0+19, repeat_pulse at t0+24, t0+29, t0+34, t0+39. On release: release_pulse only, no short_pulse.
- Priority: mode and inc rise together -> press_pulse[1] only, active_id=1. While mode is held, an inc release/re-press gives no strobes. Release mode with inc held -> no inc strobes until inc is released and re-pressed.
- Reset mid-hold: assert reset at hold count 10 -> all outputs 0 immediately. After reset deasserts, no long_pulse appears even though the button stays high.
